// File: rtl/cache_ctrl_2way_wb_if.sv
`default_nettype none
// ============================================================================
// Module      : cache_ctrl_2way_wb_if
// Description : Bus bundle for the 2-way write-back cache controller. Carries
//               the CPU request port, the external data-array port and the
//               word-wide main-memory handshake.
//               slave  : controller view (cache_ctrl_2way_wb)
//               master : environment view (CPU, data RAM, memory)
// Revision    : 1.0 - initial release
// ============================================================================
interface cache_ctrl_2way_wb_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int IDX_W  = 2,
    parameter int OFF_W  = 2
);
    // CPU side
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ready;
    logic              cpu_hit;
    // External data array
    logic              da_way;
    logic [IDX_W-1:0]  da_index;
    logic [OFF_W-1:0]  da_word;
    logic              da_we;
    logic [DATA_W-1:0] da_wdata;
    logic [DATA_W-1:0] da_rdata;
    // Main memory, one word per request/ack
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, da_rdata, mem_rdata, mem_ack,
        output cpu_rdata, cpu_ready, cpu_hit,
        output da_way, da_index, da_word, da_we, da_wdata,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, da_rdata, mem_rdata, mem_ack,
        input  cpu_rdata, cpu_ready, cpu_hit,
        input  da_way, da_index, da_word, da_we, da_wdata,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/cache_ctrl_2way_wb.sv
`default_nettype none
// ============================================================================
// Module      : cache_ctrl_2way_wb
// Description : Sequencing controller for a 2-way set-associative write-back
//               cache. Holds tag/valid/dirty/LRU state, runs the hit/miss
//               FSM, drives an external data array and moves whole blocks
//               to/from main memory one word per request/ack.
// Ports       : clk_i   - rising-edge clock
//               rst_ni  - synchronous active-low reset
//               bus     - slave view of cache_ctrl_2way_wb_if (CPU request
//                         port, data-array port, memory handshake)
// Revision    : 1.0 - initial release
// ============================================================================
module cache_ctrl_2way_wb #(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 32,
    parameter int SETS        = 4,
    parameter int BLOCK_WORDS = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    cache_ctrl_2way_wb_if.slave  bus
);
    localparam int IDX_W = $clog2(SETS);
    localparam int OFF_W = $clog2(BLOCK_WORDS);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W - 2;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_WRITEBACK = 2'd1;
    localparam logic [1:0] S_REFILL    = 2'd2;
    localparam logic [1:0] S_RESPOND   = 2'd3;

    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(BLOCK_WORDS - 1);

    // Cache bookkeeping; valid/dirty are indexed [set][way]
    logic [TAG_W-1:0] tag_q   [2][SETS];
    logic [1:0]       valid_q [SETS];
    logic [1:0]       dirty_q [SETS];
    logic [SETS-1:0]  lru_q;            // way to evict next in each set

    logic [1:0]        state_q, state_d;
    logic [OFF_W-1:0]  cnt_q, cnt_d;
    logic              miss_q, miss_d;
    logic              victim_q, victim_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    // Address fields (request is held stable until completion)
    logic [IDX_W-1:0] w_idx;
    logic [OFF_W-1:0] w_off;
    logic [TAG_W-1:0] w_tag;
    logic             w_unused;

    assign w_idx    = bus.cpu_addr[OFF_W+2 +: IDX_W];
    assign w_off    = bus.cpu_addr[2 +: OFF_W];
    assign w_tag    = bus.cpu_addr[ADDR_W-1 -: TAG_W];
    assign w_unused = &{1'b0, bus.cpu_addr[1:0]};

    // Lookup
    logic       w_hit0, w_hit1, w_hit, w_hit_way;
    logic [1:0] w_set_valid;
    logic       w_victim, w_victim_dirty;

    assign w_set_valid = valid_q[w_idx];
    assign w_hit0      = w_set_valid[0] && (tag_q[0][w_idx] == w_tag);
    assign w_hit1      = w_set_valid[1] && (tag_q[1][w_idx] == w_tag);
    assign w_hit       = w_hit0 || w_hit1;
    assign w_hit_way   = w_hit1;

    // Fill an invalid way first (way0 preferred); otherwise evict the LRU way
    assign w_victim       = !w_set_valid[0] ? 1'b0 :
                            (!w_set_valid[1] ? 1'b1 : lru_q[w_idx]);
    assign w_victim_dirty = w_set_valid[w_victim] && dirty_q[w_idx][w_victim];

    logic w_lookup_hit;   // IDLE lookup with a request that hits
    logic w_fill_done;    // last refill word acknowledged

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        miss_d       = miss_q;
        victim_d     = victim_q;
        rdata_d      = rdata_q;
        w_lookup_hit = 1'b0;
        w_fill_done  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.cpu_req) begin
                    if (w_hit) begin
                        w_lookup_hit = 1'b1;
                        if (!bus.cpu_we) begin
                            rdata_d = bus.da_rdata;
                        end
                        state_d = S_RESPOND;
                    end else begin
                        miss_d   = 1'b1;
                        victim_d = w_victim;
                        cnt_d    = '0;
                        state_d  = w_victim_dirty ? S_WRITEBACK : S_REFILL;
                    end
                end
            end
            S_WRITEBACK: begin
                if (bus.mem_ack) begin
                    cnt_d = cnt_q + OFF_W'(1);
                    if (cnt_q == LAST_WORD) begin
                        cnt_d   = '0;
                        state_d = S_REFILL;
                    end
                end
            end
            S_REFILL: begin
                if (bus.mem_ack) begin
                    cnt_d = cnt_q + OFF_W'(1);
                    if (cnt_q == LAST_WORD) begin
                        cnt_d       = '0;
                        w_fill_done = 1'b1;
                        // Re-lookup in IDLE now hits and completes the access
                        state_d     = S_IDLE;
                    end
                end
            end
            S_RESPOND: begin
                miss_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            miss_q   <= 1'b0;
            victim_q <= 1'b0;
            rdata_q  <= '0;
            lru_q    <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= 2'b00;
                dirty_q[s] <= 2'b00;
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            miss_q   <= miss_d;
            victim_q <= victim_d;
            rdata_q  <= rdata_d;
            if (w_lookup_hit) begin
                lru_q[w_idx] <= ~w_hit_way;
                if (bus.cpu_we) begin
                    dirty_q[w_idx][w_hit_way] <= 1'b1;
                end
            end
            if (w_fill_done) begin
                valid_q[w_idx][victim_q] <= 1'b1;
                dirty_q[w_idx][victim_q] <= 1'b0;
            end
        end
    end

    // Tags need no reset: they are only trusted behind a valid bit
    always_ff @(posedge clk_i) begin
        if (w_fill_done) begin
            tag_q[victim_q][w_idx] <= w_tag;
        end
    end

    logic             w_in_xfer;
    logic [TAG_W-1:0] w_mem_tag;

    assign w_in_xfer = (state_q == S_WRITEBACK) || (state_q == S_REFILL);
    assign w_mem_tag = (state_q == S_WRITEBACK) ? tag_q[victim_q][w_idx] : w_tag;

    assign bus.cpu_ready = (state_q == S_RESPOND);
    assign bus.cpu_hit   = (state_q == S_RESPOND) && !miss_q;
    assign bus.cpu_rdata = rdata_q;

    assign bus.da_way    = (state_q == S_IDLE) ? w_hit_way : victim_q;
    assign bus.da_index  = w_idx;
    assign bus.da_word   = w_in_xfer ? cnt_q : w_off;
    assign bus.da_we     = (w_lookup_hit && bus.cpu_we) ||
                           ((state_q == S_REFILL) && bus.mem_ack);
    assign bus.da_wdata  = (state_q == S_REFILL) ? bus.mem_rdata : bus.cpu_wdata;

    assign bus.mem_req   = w_in_xfer;
    assign bus.mem_we    = (state_q == S_WRITEBACK);
    assign bus.mem_addr  = {w_mem_tag, w_idx, cnt_q, 2'b00};
    assign bus.mem_wdata = bus.da_rdata;

endmodule
`default_nettype wire

// File: tb/tb_cache_ctrl_2way_wb.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_cache_ctrl_2way_wb
// Description : Self-checking bench for cache_ctrl_2way_wb. Provides the data
//               RAM and a word memory with configurable ack delay; predicts
//               hit/miss, latency, read data and memory traffic from an
//               abstract cache model and a flat architectural memory image.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_ctrl_2way_wb;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    cache_ctrl_2way_wb_if #(.ADDR_W(10), .DATA_W(32), .IDX_W(2), .OFF_W(2)) bus ();

    cache_ctrl_2way_wb #(
        .ADDR_W(10), .DATA_W(32), .SETS(4), .BLOCK_WORDS(4)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    // External data array
    logic [31:0] da_mem [2][4][4];
    always @(posedge clk) if (bus.da_we) da_mem[bus.da_way][bus.da_index][bus.da_word] <= bus.da_wdata;
    assign bus.da_rdata = da_mem[bus.da_way][bus.da_index][bus.da_word];

    // Physical main memory (what the DUT wrote back) and architectural image
    logic [31:0] mem_img [256] = '{default: 32'h0};
    logic [31:0] ref_img [256];

    typedef struct packed {
        logic        we;
        logic [9:0]  addr;
        logic [31:0] data;
    } mtx_t;
    mtx_t exp_q [$];

    // Abstract cache model
    bit m_valid [4][2];
    bit m_dirty [4][2];
    int m_tag   [4][2];
    int m_lru   [4];

    int n_tests = 0;
    int n_fail  = 0;

    // Expectation of the access in flight (written by driver, read by checker)
    bit          active = 0;
    int          req_id = 0;
    int          done_id = 0;
    int          start_cyc, e_base, wait_start;
    bit          e_hit, e_we;
    logic [31:0] e_rdata;
    int          dly_mode = 0;
    // Results captured by checker
    int          got_lat;
    bit          got_hit;
    logic [31:0] got_rdata;

    int          wait_cnt = 0;
    int          wait_left = 0;
    bit          prev_wait = 0;
    bit          prev_we;
    logic [9:0]  prev_addr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int pick_delay();
        case (dly_mode)
            0:       return 0;
            1:       return 3;
            default: return int'($urandom_range(0, 3));
        endcase
    endfunction

    // Single compare process; also acts as the memory responder
    always @(negedge clk) begin
        logic ack;
        mtx_t t;
        ack = 1'b0;
        if (rst_n) begin
            if (prev_wait)
                chk("mem_hold", {bus.mem_req, bus.mem_we, bus.mem_addr}, {1'b1, prev_we, prev_addr});
            if (bus.da_we)
                chk("da_we_legal", bus.mem_req ? !bus.mem_we : (bus.cpu_req && bus.cpu_we), 1'b1);
            if (bus.cpu_ready) begin
                if (!active || done_id == req_id) begin
                    chk("unexpected_ready", 1'b1, 1'b0);
                end else begin
                    got_lat   = cyc - start_cyc;
                    got_hit   = bus.cpu_hit;
                    got_rdata = bus.cpu_rdata;
                    chk("latency", got_lat, e_base + (wait_cnt - wait_start));
                    chk("cpu_hit", got_hit, e_hit);
                    if (!e_we) chk("cpu_rdata", got_rdata, e_rdata);
                    chk("mem_xfers_left", exp_q.size(), 0);
                    done_id = req_id;
                end
            end
            if (bus.mem_req) begin
                if (wait_left == 0) begin
                    ack = 1'b1;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_mem_req", {bus.mem_we, bus.mem_addr}, 11'h7ff);
                    end else begin
                        t = exp_q.pop_front();
                        chk("mem_we", bus.mem_we, t.we);
                        chk("mem_addr", bus.mem_addr, t.addr);
                        if (t.we) chk("mem_wdata", bus.mem_wdata, t.data);
                    end
                    if (bus.mem_we) mem_img[bus.mem_addr[9:2]] = bus.mem_wdata;
                    else            bus.mem_rdata = mem_img[bus.mem_addr[9:2]];
                    wait_left = pick_delay();
                end else begin
                    wait_left--;
                    wait_cnt++;
                end
            end else begin
                wait_left = pick_delay();
            end
            prev_wait = bus.mem_req && !ack;
            prev_we   = bus.mem_we;
            prev_addr = bus.mem_addr;
        end else begin
            prev_wait = 1'b0;
        end
        bus.mem_ack = ack;
    end

    task automatic clear_model();
        for (int s = 0; s < 4; s++) begin
            m_lru[s] = 0;
            for (int w = 0; w < 2; w++) begin
                m_valid[s][w] = 0;
                m_dirty[s][w] = 0;
                m_tag[s][w]   = 0;
            end
        end
        exp_q.delete();
        // Dirty lines are lost on reset: architectural state reverts to memory
        for (int a = 0; a < 256; a++) ref_img[a] = mem_img[a];
    endtask

    task automatic apply_reset(input int cycles);
        rst_n = 1'b0;
        bus.cpu_req = 1'b0;
        active = 0;
        repeat (cycles) @(posedge clk);
        #2;
        chk("rst_mem_req", bus.mem_req, 1'b0);
        chk("rst_cpu_ready", bus.cpu_ready, 1'b0);
        chk("rst_da_we", bus.da_we, 1'b0);
        clear_model();
        rst_n = 1'b1;
    endtask

    // Called at posedge+2. abort=1 resets the DUT during refill word 2.
    task automatic do_access(input bit we, input logic [9:0] addr, input logic [31:0] wd,
                             input bit abort);
        int idx, tg, way, vic;
        mtx_t t;
        bit finished;
        idx = int'(addr[5:4]);
        tg  = int'(addr[9:6]);
        way = -1;
        for (int w = 0; w < 2; w++)
            if (m_valid[idx][w] && m_tag[idx][w] == tg) way = w;
        e_we    = we;
        e_rdata = ref_img[addr[9:2]];
        if (way >= 0) begin
            e_hit  = 1;
            e_base = 1;
            if (we) m_dirty[idx][way] = 1;
            m_lru[idx] = 1 - way;
        end else begin
            e_hit  = 0;
            e_base = 6;
            vic = !m_valid[idx][0] ? 0 : (!m_valid[idx][1] ? 1 : m_lru[idx]);
            if (m_valid[idx][vic] && m_dirty[idx][vic]) begin
                e_base = 10;
                for (int w = 0; w < 4; w++) begin
                    t.we   = 1'b1;
                    t.addr = 10'(m_tag[idx][vic] * 64 + idx * 16 + w * 4);
                    t.data = ref_img[t.addr[9:2]];
                    exp_q.push_back(t);
                end
            end
            for (int w = 0; w < 4; w++) begin
                t.we   = 1'b0;
                t.addr = 10'(tg * 64 + idx * 16 + w * 4);
                t.data = 32'h0;
                exp_q.push_back(t);
            end
            m_valid[idx][vic] = 1;
            m_tag[idx][vic]   = tg;
            m_dirty[idx][vic] = we;
            m_lru[idx]        = 1 - vic;
        end
        if (we) ref_img[addr[9:2]] = wd;
        wait_start    = wait_cnt;
        start_cyc     = cyc;
        req_id++;
        active        = 1;
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wd;
        finished = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #2;
            if (done_id == req_id) begin
                finished = 1;
                break;
            end
            if (abort && bus.mem_req && !bus.mem_we && bus.da_word == 2'd2) break;
        end
        bus.cpu_req = 1'b0;
        active = 0;
        if (!finished) begin
            if (!abort) chk("access_timeout", 1'b1, 1'b0);
            apply_reset(1);
        end
    endtask

    task automatic expect_result(input string name, input int lat, input bit hit,
                                 input logic [31:0] rdata, input bit chk_rd);
        chk({name, "_lat"}, got_lat, lat);
        chk({name, "_hit"}, got_hit, hit);
        if (chk_rd) chk({name, "_rdata"}, got_rdata, rdata);
    endtask

    initial begin
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        for (int a = 0; a < 256; a++) ref_img[a] = 32'h0;
        @(posedge clk);
        apply_reset(3);
        chk("rst_cpu_hit", bus.cpu_hit, 1'b0);
        chk("rst_cpu_rdata", bus.cpu_rdata, 32'h0);

        // Directed walk-through with hand-computed expectations
        @(posedge clk); #2;
        do_access(0, 10'h000, 32'h0, 0);
        expect_result("cold_read", 6, 0, 32'h0, 1);
        @(posedge clk); #2;
        do_access(1, 10'h000, 32'h000000FF, 0);
        expect_result("hit_write", 1, 1, 32'h0, 0);
        chk("no_write_through", mem_img[0], 32'h0);
        @(posedge clk); #2;
        do_access(0, 10'h000, 32'h0, 0);
        expect_result("hit_read", 1, 1, 32'h000000FF, 1);
        @(posedge clk); #2;
        do_access(0, 10'h200, 32'h0, 0);
        expect_result("fill_way1", 6, 0, 32'h0, 1);
        @(posedge clk); #2;
        do_access(0, 10'h000, 32'h0, 0);
        expect_result("retained", 1, 1, 32'h000000FF, 1);
        @(posedge clk); #2;
        do_access(0, 10'h300, 32'h0, 0);
        expect_result("evict_clean", 6, 0, 32'h0, 1);
        @(posedge clk); #2;
        do_access(0, 10'h200, 32'h0, 0);
        expect_result("evict_dirty", 10, 0, 32'h0, 1);
        chk("writeback_word0", mem_img[0], 32'h000000FF);

        dly_mode = 1;
        @(posedge clk); #2;
        do_access(0, 10'h010, 32'h0, 0);
        expect_result("slow_mem", 18, 0, 32'h0, 1);
        dly_mode = 0;

        // Reset in the middle of a refill, then the same read misses again
        @(posedge clk); #2;
        do_access(0, 10'h020, 32'h0, 1);
        @(posedge clk); #2;
        do_access(0, 10'h020, 32'h0, 0);
        expect_result("after_abort", 6, 0, 32'h0, 1);

        // Randomised traffic over a few conflicting tags per set
        for (int n = 0; n < 250; n++) begin
            logic [9:0] a;
            dly_mode = (n % 3 == 0) ? 2 : 0;
            a = {2'($urandom_range(0, 3)) + 2'(0), 2'b00, 2'($urandom_range(0, 3)),
                 2'($urandom_range(0, 3)), 2'b00};
            a[9:6] = 4'($urandom_range(0, 3));
            repeat ($urandom_range(1, 2)) @(posedge clk);
            #2;
            do_access(1'($urandom_range(0, 1)), a, $urandom, 0);
        end

        @(posedge clk); #2;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end
endmodule
`default_nettype wire
